serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 28 ++
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bundle for serial_adder
//   start  : request, sampled only while the adder is idle
//   a, b   : WIDTH-bit operands, captured on the accepting edge
//   busy   : addition in progress
//   done   : one-cycle pulse when sum/cout become valid
//   sum    : registered result a+b mod 2^WIDTH
//   cout   : registered carry out of bit WIDTH-1
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell, LSB first, registered carry
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_adder_if slave (start, a, b in; busy, done, sum, cout out)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-adder cell built from two half-adder stages plus an OR.
  logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;

  always_comb begin
    ha1_s = a_sh_q[0] ^ b_sh_q[0];
    ha1_c = a_sh_q[0] & b_sh_q[0];
    fa_s  = ha1_s ^ carry_q;
    ha2_c = ha1_s & carry_q;
    fa_c  = ha1_c | ha2_c;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        acc_d   = WIDTH'({fa_s, acc_q} >> 1);
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the completed word including the bit produced this cycle.
          sum_d   = acc_d;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered decodes of the next state.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete addition from IDLE: accept, run, done pulse, back to IDLE.
  task automatic do_add(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] es, input logic ec);
    int         n;
    logic [7:0] prev;
    prev      = bus.sum;
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    tick();
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    check("busy_after_accept", bus.busy, 1);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      check("sum_stable_in_run", bus.sum, prev);
      check("busy_in_run", bus.busy, 1);
      tick();
      n++;
    end
    check("run_cycles", n, W);
    check("done_pulse", bus.done, 1);
    check("busy_in_done", bus.busy, 0);
    check("sum_result", bus.sum, es);
    check("cout_result", bus.cout, ec);
    tick();
    check("done_one_cycle", bus.done, 0);
    check("busy_back_idle", bus.busy, 0);
    check("sum_held", bus.sum, es);
  endtask

  initial begin
    int         last_done;
    int         low_cnt;
    int         num_done;
    int         n;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] ref_sum;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};
    vecs[3] = '{a: 8'hA5, b: 8'h5A, sum: 8'hFF, cout: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h7F, sum: 8'hFF, cout: 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_sum", bus.sum, 0);
    check("reset_cout", bus.cout, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout);
    end

    // New request during RUN must be ignored and not queued.
    bus.start = 1'b1;
    bus.a     = 8'h0F;
    bus.b     = 8'h01;
    tick();
    bus.a = 8'hF0;
    bus.b = 8'hF0;
    tick();
    tick();
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ignore_start_done", bus.done, 1);
    check("ignore_start_sum", bus.sum, 8'h10);
    check("ignore_start_cout", bus.cout, 0);
    num_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.busy === 1'b1 || bus.done === 1'b1) num_done++;
    end
    check("not_queued", num_done, 0);

    // Back-to-back with start held: period W+2, busy low for 2 cycles.
    bus.start = 1'b1;
    bus.a     = 8'h03;
    bus.b     = 8'h04;
    last_done = -1;
    low_cnt   = 0;
    num_done  = 0;
    n         = 0;
    while (num_done < 3 && n < 40) begin
      tick();
      n++;
      if (bus.done === 1'b1) begin
        check("held_sum", bus.sum, 8'h07);
        check("held_busy_done_excl", bus.busy, 0);
        if (last_done >= 0) begin
          check("held_period", n - last_done, W + 2);
          check("held_busy_low", low_cnt, 2);
        end
        last_done = n;
        low_cnt   = 0;
        num_done++;
      end
      if (bus.busy === 1'b0) low_cnt++;
    end
    bus.start = 1'b0;
    check("held_done_count", num_done, 3);
    tick();
    tick();

    // Reset in the 4th RUN cycle aborts without a done pulse.
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h80;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_sum", bus.sum, 0);
    check("abort_cout", bus.cout, 0);
    num_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) num_done++;
    end
    check("abort_no_done", num_done, 0);
    do_add(8'h80, 8'h80, 8'h00, 1'b1);

    // Reset and start on the same edge: reset wins.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", bus.busy, 0);
    tick();
    check("rst_start_not_accepted", bus.busy, 0);
    check("rst_start_sum", bus.sum, 0);

    // Random sweep against plain arithmetic.
    for (int i = 0; i < 200; i++) begin
      ra      = 8'($urandom);
      rb      = 8'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb};
      do_add(ra, rb, ref_sum[7:0], ref_sum[8]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
